// File: rtl/fp_sig_mul_if.sv
// Handshake and operand/result bundle for the iterative significand multiplier.
// The master drives requests and operands; the slave (multiplier) returns the product.
interface fp_sig_mul_if #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
);
  logic                start;
  logic                a_sign;
  logic [NEXP-1:0]     a_exp;
  logic [NSIG:0]       a_sig;
  logic                b_sign;
  logic [NEXP-1:0]     b_exp;
  logic [NSIG:0]       b_sig;
  logic                busy;
  logic                done;
  logic                p_sign;
  logic [NEXP+1:0]     p_exp;
  logic [2*NSIG+1:0]   pSig;
  logic                p_zero;

  modport master (
    output start, a_sign, a_exp, a_sig, b_sign, b_exp, b_sig,
    input  busy, done, p_sign, p_exp, pSig, p_zero
  );

  modport slave (
    input  start, a_sign, a_exp, a_sig, b_sign, b_exp, b_sig,
    output busy, done, p_sign, p_exp, pSig, p_zero
  );
endinterface

// File: rtl/fp_sig_mul.sv
// Iterative shift-add significand multiplier feeding the round stage.
// Define FP_SIG_MUL_RADIX4_EN to retire two multiplier bits per cycle using a precomputed 3x multiplicand.
module fp_sig_mul #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_sig_mul_if.slave  bus
);
  localparam int SW   = NSIG + 1;
  localparam int PW   = 2 * NSIG + 2;
  localparam int EW   = NEXP + 2;
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
`ifdef FP_SIG_MUL_RADIX4_EN
  localparam int ITERS = (SW + 1) / 2;
  localparam int BW    = 2 * ITERS;
`else
  localparam int ITERS = SW;
  localparam int BW    = SW;
`endif
  localparam int CW = $clog2(ITERS + 1);

  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   mcand;
  logic [BW-1:0]   mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            sign_r;
  logic [EW-1:0]   exp_r;
  logic            done_r, p_sign_r, p_zero_r;
  logic [EW-1:0]   p_exp_r;
  logic [PW-1:0]   p_sig_r;
  logic            busy_c, is_zero;
  logic [PW-1:0]   norm_sig;
  logic [EW-1:0]   norm_exp;
  logic            iter_last;

  assign iter_last = (cnt == CW'(ITERS));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = MUL;
      MUL:     if (iter_last) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    busy_c   = (state != IDLE);
    is_zero  = (acc == '0);
    norm_sig = '0;
    norm_exp = '0;
    if (!is_zero) begin
      if (acc[PW-1]) begin
        norm_sig = acc;
        norm_exp = exp_r + EW'(1);
      end else begin
        norm_sig = {acc[PW-2:0], 1'b0};
        norm_exp = exp_r;
      end
    end
  end

`ifdef FP_SIG_MUL_RADIX4_EN
  logic [PW-1:0] mcand3;
  logic [PW-1:0] addend;

  always_comb begin
    addend = '0;
    case (mplier[1:0])
      2'd1:    addend = mcand;
      2'd2:    addend = {mcand[PW-2:0], 1'b0};
      2'd3:    addend = mcand3;
      default: addend = '0;
    endcase
  end
`endif

  // NOTE: all datapath registers are small flops, so they share the async reset with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign_r   <= 1'b0;
      exp_r    <= '0;
      done_r   <= 1'b0;
      p_sign_r <= 1'b0;
      p_exp_r  <= '0;
      p_sig_r  <= '0;
      p_zero_r <= 1'b0;
`ifdef FP_SIG_MUL_RADIX4_EN
      mcand3   <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          mcand  <= PW'(bus.a_sig);
          mplier <= BW'(bus.b_sig);
          acc    <= '0;
          cnt    <= '0;
          sign_r <= bus.a_sign ^ bus.b_sign;
          exp_r  <= {2'b00, bus.a_exp} + {2'b00, bus.b_exp} - EW'(BIAS);
`ifdef FP_SIG_MUL_RADIX4_EN
          mcand3 <= PW'({bus.a_sig, 1'b0}) + PW'(bus.a_sig);
`endif
        end
        MUL: if (!iter_last) begin
          // Multiplicand shifts alongside the multiplier, so it always sits at the current bit weight.
`ifdef FP_SIG_MUL_RADIX4_EN
          acc    <= acc + addend;
          mcand  <= mcand << 2;
          mcand3 <= mcand3 << 2;
          mplier <= mplier >> 2;
`else
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
`endif
          cnt <= cnt + CW'(1);
        end
        NORM: begin
          p_sign_r <= sign_r;
          p_exp_r  <= norm_exp;
          p_sig_r  <= norm_sig;
          p_zero_r <= is_zero;
          done_r   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_r;
  assign bus.p_sign = p_sign_r;
  assign bus.p_exp  = p_exp_r;
  assign bus.pSig   = p_sig_r;
  assign bus.p_zero = p_zero_r;
endmodule

// File: tb/tb_fp_sig_mul.sv
// Directed self-checking bench for fp_sig_mul: vectors, zero/underflow, ignored start,
// back-to-back start in the done cycle and asynchronous reset mid-operation.
module tb_fp_sig_mul;
  localparam int NEXP = 8;
  localparam int NSIG = 7;
`ifdef FP_SIG_MUL_RADIX4_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 10;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  fp_sig_mul_if #(.NEXP(NEXP), .NSIG(NSIG)) bus ();

  fp_sig_mul #(.NEXP(NEXP), .NSIG(NSIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       as;
    logic [7:0] ae;
    logic [7:0] asig;
    logic       bs;
    logic [7:0] be;
    logic [7:0] bsig;
    logic [15:0] psig;
    logic [9:0]  pexp;
    logic        psign;
    logic        pzero;
  } vec_t;

  task automatic launch(input logic as, input logic [7:0] ae, input logic [7:0] asig,
                        input logic bs, input logic [7:0] be, input logic [7:0] bsig);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a_sign = as;  bus.a_exp = ae;  bus.a_sig = asig;
    bus.b_sign = bs;  bus.b_exp = be;  bus.b_sig = bsig;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a_sig = 8'h00;
    bus.b_sig = 8'h00;
  endtask

  // Counts edges after the start edge until done is seen; gives up after 50.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 50);
  endtask

  task automatic test_reset;
    n_checks++;
    if ({bus.busy, bus.done, bus.p_sign, bus.p_exp, bus.pSig, bus.p_zero} !== 30'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b sign=%b exp=%h sig=%h zero=%b, want all 0",
               bus.busy, bus.done, bus.p_sign, bus.p_exp, bus.pSig, bus.p_zero);
    else n_pass++;
  endtask

  task automatic test_vectors;
    vec_t v [8];
    int   lat;
    v[0] = '{1'b0, 8'd127, 8'h80, 1'b0, 8'd127, 8'h80, 16'h8000, 10'd127, 1'b0, 1'b0};
    v[1] = '{1'b0, 8'd127, 8'hC0, 1'b0, 8'd127, 8'hC0, 16'h9000, 10'd128, 1'b0, 1'b0};
    v[2] = '{1'b1, 8'd130, 8'hFF, 1'b0, 8'd120, 8'hFF, 16'hFE01, 10'd124, 1'b1, 1'b0};
    v[3] = '{1'b0, 8'd1,   8'h00, 1'b1, 8'd1,   8'hA5, 16'h0000, 10'h000, 1'b1, 1'b1};
    v[4] = '{1'b0, 8'd1,   8'h80, 1'b0, 8'd1,   8'h80, 16'h8000, 10'h383, 1'b0, 1'b0};
    v[5] = '{1'b1, 8'd254, 8'hFF, 1'b1, 8'd254, 8'hFF, 16'hFE01, 10'h17E, 1'b0, 1'b0};
    v[6] = '{1'b1, 8'd100, 8'h81, 1'b1, 8'd100, 8'h81, 16'h8202, 10'd73,  1'b0, 1'b0};
    v[7] = '{1'b0, 8'd127, 8'h80, 1'b1, 8'd127, 8'hFF, 16'hFF00, 10'd127, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      launch(v[i].as, v[i].ae, v[i].asig, v[i].bs, v[i].be, v[i].bsig);
      n_checks++;
      if (bus.busy !== 1'b1) $display("FAIL vec%0d_busy: got %b want 1", i, bus.busy);
      else n_pass++;
      wait_done(lat);
      n_checks++;
      if (lat !== LAT) $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, LAT);
      else n_pass++;
      n_checks++;
      if (bus.pSig !== v[i].psig) $display("FAIL vec%0d_psig: got %h want %h", i, bus.pSig, v[i].psig);
      else n_pass++;
      n_checks++;
      if (bus.p_exp !== v[i].pexp) $display("FAIL vec%0d_pexp: got %h want %h", i, bus.p_exp, v[i].pexp);
      else n_pass++;
      n_checks++;
      if ({bus.p_sign, bus.p_zero} !== {v[i].psign, v[i].pzero})
        $display("FAIL vec%0d_sign_zero: got %b%b want %b%b", i, bus.p_sign, bus.p_zero, v[i].psign, v[i].pzero);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL vec%0d_busy_clear: got %b want 0", i, bus.busy);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.done !== 1'b0 || bus.pSig !== v[i].psig)
        $display("FAIL vec%0d_pulse_hold: got done=%b sig=%h want done=0 sig=%h", i, bus.done, bus.pSig, v[i].psig);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int rest;
    launch(1'b0, 8'd127, 8'h80, 1'b0, 8'd127, 8'h80);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_sig = 8'hFF; bus.b_sig = 8'hFF; bus.a_exp = 8'd10; bus.b_exp = 8'd10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(rest);
    lat = 3 + rest;
    n_checks++;
    if (lat !== LAT) $display("FAIL ignore_latency: got %0d want %0d", lat, LAT);
    else n_pass++;
    n_checks++;
    if (bus.pSig !== 16'h8000 || bus.p_exp !== 10'd127)
      $display("FAIL ignore_result: got sig=%h exp=%h want sig=8000 exp=07f", bus.pSig, bus.p_exp);
    else n_pass++;
    // Start in the done cycle itself.
    bus.start  = 1'b1;
    bus.a_sig  = 8'hC0; bus.b_sig = 8'hC0;
    bus.a_exp  = 8'd127; bus.b_exp = 8'd127;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", bus.busy);
    else n_pass++;
    wait_done(lat);
    n_checks++;
    if (lat !== LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, LAT);
    else n_pass++;
    n_checks++;
    if (bus.pSig !== 16'h9000 || bus.p_exp !== 10'd128)
      $display("FAIL b2b_result: got sig=%h exp=%h want sig=9000 exp=080", bus.pSig, bus.p_exp);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int lat;
    launch(1'b1, 8'd127, 8'h80, 1'b0, 8'd127, 8'h80);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.p_sign, bus.p_exp, bus.pSig, bus.p_zero} !== 30'd0)
      $display("FAIL midreset_outputs: got busy=%b done=%b sign=%b exp=%h sig=%h zero=%b want all 0",
               bus.busy, bus.done, bus.p_sign, bus.p_exp, bus.pSig, bus.p_zero);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    launch(1'b0, 8'd127, 8'hC0, 1'b0, 8'd127, 8'hC0);
    wait_done(lat);
    n_checks++;
    if (lat !== LAT) $display("FAIL midreset_latency: got %0d want %0d", lat, LAT);
    else n_pass++;
    n_checks++;
    if (bus.pSig !== 16'h9000 || bus.p_exp !== 10'd128 || bus.p_sign !== 1'b0)
      $display("FAIL midreset_result: got sig=%h exp=%h sign=%b want sig=9000 exp=080 sign=0",
               bus.pSig, bus.p_exp, bus.p_sign);
    else n_pass++;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.a_sign = 1'b0; bus.a_exp = '0; bus.a_sig = '0;
    bus.b_sign = 1'b0; bus.b_exp = '0; bus.b_sig = '0;
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_vectors;
    test_back_to_back;
    test_mid_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
